// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_kbd_pkg : scan-code constants, key indices, key-match helper   |
// | Config macro: KBD_WASD_EN (adds W/A/S/D alias keys)    Rev 1.0     |
// +--------------------------------------------------------------------+
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

`ifdef KBD_WASD_EN
  localparam int NUM_KEYS  = 10;
  localparam int KEY_IDX_W = 4;
  typedef enum logic [KEY_IDX_W-1:0] {
    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_SPACE, KEY_ESC,
    KEY_W, KEY_A, KEY_S, KEY_D
  } key_idx_e;
`else
  localparam int NUM_KEYS  = 6;
  localparam int KEY_IDX_W = 3;
  typedef enum logic [KEY_IDX_W-1:0] {
    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_SPACE, KEY_ESC
  } key_idx_e;
`endif

  // One-hot of the held-bits a code touches; the ext prefix must match the key's attribute.
  function automatic logic [NUM_KEYS-1:0] key_hit(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] hit;
    hit             = '0;
    hit[KEY_UP]     = ext  && (code == SC_UP);
    hit[KEY_DOWN]   = ext  && (code == SC_DOWN);
    hit[KEY_LEFT]   = ext  && (code == SC_LEFT);
    hit[KEY_RIGHT]  = ext  && (code == SC_RIGHT);
    hit[KEY_SPACE]  = !ext && (code == SC_SPACE);
    hit[KEY_ESC]    = !ext && (code == SC_ESC);
`ifdef KBD_WASD_EN
    hit[KEY_W]      = !ext && (code == SC_W);
    hit[KEY_A]      = !ext && (code == SC_A);
    hit[KEY_S]      = !ext && (code == SC_S);
    hit[KEY_D]      = !ext && (code == SC_D);
`endif
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_rx : PS/2 line sync, clock glitch filter, frame receive/check  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [10:0]   shift_q, shift_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          fall;
  logic [10:0]   frame;
  logic          frame_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      tcnt_q      <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      tcnt_q      <= tcnt_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  assign frame    = {data_sync_q[1], shift_q[10:1]};
  assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    tcnt_d   = tcnt_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (fall) begin
      tcnt_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = '0;
        shift_d  = '0;
        valid_d  = frame_ok;
        err_d    = !frame_ok;
        if (frame_ok) byte_d = frame[8:1];
      end else begin
        bitcnt_d = bitcnt_q + 4'd1;
        shift_d  = frame;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        bitcnt_d = '0;
        shift_d  = '0;
        tcnt_d   = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  assign rx_byte_o  = byte_q;
  assign rx_valid_o = valid_q;
  assign rx_err_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_keyboard : PS/2 set-2 make/break decoder with held-key levels  |
// | Config macro: KBD_WASD_EN (W/A/S/D alias arrows)       Rev 1.0     |
// +--------------------------------------------------------------------+
module ps2_keyboard #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic clk_25MHz,
  input  logic rst,
  input  logic PS2Clk,
  input  logic PS2Data,
  output logic upKeyState,
  output logic downKeyState,
  output logic leftKeyState,
  output logic rightKeyState,
  output logic spaceKeyState,
  output logic escKeyState
);
  import ps2_kbd_pkg::*;

  logic [7:0]          rx_byte;
  logic                rx_valid, rx_err;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d, hit;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_i     (clk_25MHz),
    .rst_ni    (rst),
    .ps2_clk_i (PS2Clk),
    .ps2_data_i(PS2Data),
    .rx_byte_o (rx_byte),
    .rx_valid_o(rx_valid),
    .rx_err_o  (rx_err)
  );

  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
    end
  end

  // A corrupted frame may have been part of a prefixed sequence, so it drops both prefixes.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    hit    = key_hit(ext_q, rx_byte);
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        keys_d = brk_q ? (keys_q & ~hit) : (keys_q | hit);
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
  end

`ifdef KBD_WASD_EN
  assign upKeyState    = keys_q[KEY_UP]    | keys_q[KEY_W];
  assign downKeyState  = keys_q[KEY_DOWN]  | keys_q[KEY_S];
  assign leftKeyState  = keys_q[KEY_LEFT]  | keys_q[KEY_A];
  assign rightKeyState = keys_q[KEY_RIGHT] | keys_q[KEY_D];
`else
  assign upKeyState    = keys_q[KEY_UP];
  assign downKeyState  = keys_q[KEY_DOWN];
  assign leftKeyState  = keys_q[KEY_LEFT];
  assign rightKeyState = keys_q[KEY_RIGHT];
`endif
  assign spaceKeyState = keys_q[KEY_SPACE];
  assign escKeyState   = keys_q[KEY_ESC];

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_keyboard : directed PS/2 frames against a held-key model    |
// | Config macro: KBD_WASD_EN (alias scenario)              Rev 1.0    |
// +--------------------------------------------------------------------+
module tb_ps2_keyboard;

  logic clk = 1'b0, rst = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
  logic up, down, left, right, space, esc;
  int   errors = 0, checks = 0;
  bit   chk_en = 1'b0;

  bit   m_ext, m_brk;
  bit   held [string];

  ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYC(1000)) dut (
    .clk_25MHz    (clk),
    .rst          (rst),
    .PS2Clk       (ps2c),
    .PS2Data      (ps2d),
    .upKeyState   (up),
    .downKeyState (down),
    .leftKeyState (left),
    .rightKeyState(right),
    .spaceKeyState(space),
    .escKeyState  (esc)
  );

  always #20 clk = ~clk;

  function automatic string key_name(bit ext, logic [7:0] code);
    if (ext) begin
      case (code)
        8'h75: return "up";
        8'h72: return "down";
        8'h6B: return "left";
        8'h74: return "right";
        default: return "";
      endcase
    end
    case (code)
      8'h29: return "space";
      8'h76: return "esc";
`ifdef KBD_WASD_EN
      8'h1D: return "w";
      8'h1C: return "a";
      8'h1B: return "s";
      8'h23: return "d";
`endif
      default: return "";
    endcase
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0;
    held["up"] = 0; held["down"] = 0; held["left"] = 0; held["right"] = 0;
    held["space"] = 0; held["esc"] = 0;
    held["w"] = 0; held["a"] = 0; held["s"] = 0; held["d"] = 0;
  endtask

  task automatic model_byte(bit ok, logic [7:0] b);
    string n;
    if (!ok) begin m_ext = 0; m_brk = 0; return; end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      n = key_name(m_ext, b);
      if (n != "") held[n] = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {held["up"] | held["w"], held["down"] | held["s"], held["left"] | held["a"],
            held["right"] | held["d"], held["space"], held["esc"]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({up, down, left, right, space, esc} !== exp_vec()) begin
        errors++;
        if (errors <= 20)
          $display("FAIL cycle_compare t=%0t actual(u,d,l,r,sp,esc)=%b required=%b",
                   $time, {up, down, left, right, space, esc}, exp_vec());
      end
    end
  end

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Data changes mid clock-high; the line falls for 40 cycles per bit.
  task automatic send_bits(logic [10:0] f, int n);
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      cyc(20);
      if (i == 10) chk_en = 0;
      ps2c = 0;
      cyc(40);
      ps2c = 1;
      cyc(20);
    end
    ps2d = 1;
  endtask

  function automatic logic [10:0] mk_frame(logic [7:0] d, bit bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send(logic [7:0] d, bit bad_par = 0);
    send_bits(mk_frame(d, bad_par), 11);
    model_byte(!bad_par, d);
    chk_en = 1;
    cyc(20);
  endtask

  initial begin
    model_reset();
    cyc(3);
    check("reset_up", up, 0);       check("reset_down", down, 0);
    check("reset_left", left, 0);   check("reset_right", right, 0);
    check("reset_space", space, 0); check("reset_esc", esc, 0);
    rst = 1;
    cyc(5);
    chk_en = 1;

    // make / typematic / break of space
    send(8'h29);
    check("space_make", space, 1);
    send(8'h29);
    check("space_typematic", space, 1);
    send(8'hF0); send(8'h29);
    check("space_break", space, 0);

    // extended arrows and extended break
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h6B);
    check("up_make", up, 1);
    check("left_make", left, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_ext_break", up, 0);
    check("left_still_held", left, 1);

    // non-extended 75 (keypad 8) ignored; escape held; unmapped codes
    send(8'h75);
    check("kp8_ignored", up, 0);
    send(8'h76);
    check("esc_make", esc, 1);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h12);
    send(8'hAA); send(8'hFA); send(8'hEE);
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'h74);
    check("down_make", down, 1);
    check("right_make", right, 1);

    // parity error: no change, and a pending E0 is dropped
    send(8'h29, 1);
    check("bad_parity_space", space, 0);
    send(8'hE0); send(8'h11, 1); send(8'h75);
    check("bad_frame_clears_ext", up, 0);
    send(8'h29);
    check("space_after_bad", space, 1);

    // timeout discards a partial frame
    send(8'hF0); send(8'h76);
    check("esc_break", esc, 0);
    send_bits(mk_frame(8'h29, 0), 5);
    cyc(1200);
    send(8'h76);
    check("esc_after_timeout", esc, 1);

    // short glitch on the clock line must not be taken as a bit
    ps2c = 0; cyc(5); ps2c = 1; cyc(30);
    send(8'hF0); send(8'h29);
    check("space_break_after_glitch", space, 0);

`ifdef KBD_WASD_EN
    send(8'h1D);
    check("w_alias_up", up, 1);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1D);
    check("up_held_after_w_release", up, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_released", up, 0);
`else
    send(8'h1D);
    check("w_unmapped", up, 0);
`endif

    // asynchronous reset mid-frame with keys held
    send(8'h29);
    send_bits(mk_frame(8'h76, 0), 5);
    chk_en = 0;
    #7 rst = 0;
    #2;
    check("rst_up", up, 0);       check("rst_down", down, 0);
    check("rst_left", left, 0);   check("rst_right", right, 0);
    check("rst_space", space, 0); check("rst_esc", esc, 0);
    model_reset();
    cyc(3);
    rst = 1;
    cyc(3);
    chk_en = 1;
    send(8'h76);
    check("esc_after_reset", esc, 1);
    check("left_after_reset", left, 0);

    cyc(10);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
